clk_div_prog: RTL



---
 rtl/clk_div_pkg.sv | 14 +
 rtl/clk_div_ch.sv | 113 +++++++++++
 rtl/clk_div_prog.sv | 36 +++
 3 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable clock divider.
package clk_div_pkg;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} ch_state_e;

   localparam int DIV_W_DEF = 8;
   localparam int MIN_DIV   = 2;

   // High-phase length of a period of n input cycles.
   function automatic logic [31:0] half(input logic [31:0] n);
      return n >> 1;
   endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: period counter, IDLE/RUN control and ratio register.
// Define ODD_DUTY50_EN to add the negedge stage that gives odd ratios a 50% duty.
module clk_div_ch
   import clk_div_pkg::*;
#(
   parameter int DIV_W   = DIV_W_DEF,
   parameter int DEF_DIV = 2
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             en,
   input  logic [DIV_W-1:0] div_in,
   input  logic             sync,
   output logic             clk_out,
   output logic             tick,
   output logic             cfg_err
);

   ch_state_e        state_q, state_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] ratio_q, ratio_d;
   logic             clk_q, clk_d;
   logic             tick_q, tick_d;
   logic             err_q, err_d;
   logic             in_ok, start, last;

   assign in_ok = (div_in >= DIV_W'(MIN_DIV));
   assign start = en && in_ok;
   assign last  = (cnt_q == ratio_q - 1'b1);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ratio_d = ratio_q;
      clk_d   = 1'b0;
      tick_d  = 1'b0;
      if (sync && start) begin
         // Phase-align restart; may cut the running period short.
         state_d = RUN;
         cnt_d   = '0;
         ratio_d = div_in;
         clk_d   = 1'b1;
         tick_d  = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               ratio_d = div_in;
               cnt_d   = '0;
               if (start) begin
                  state_d = RUN;
                  clk_d   = 1'b1;
                  tick_d  = 1'b1;
               end
            end
            RUN: begin
               if (last) begin
                  // Period boundary: the only point where en/div_in are honoured.
                  ratio_d = div_in;
                  cnt_d   = '0;
                  if (start) begin
                     clk_d  = 1'b1;
                     tick_d = 1'b1;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
                  clk_d = (32'(cnt_d) < half(32'(ratio_q)));
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign err_d = (ratio_d < DIV_W'(MIN_DIV));

   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ratio_q <= DIV_W'(DEF_DIV);
         clk_q   <= 1'b0;
         tick_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ratio_q <= ratio_d;
         clk_q   <= clk_d;
         tick_q  <= tick_d;
         err_q   <= err_d;
      end
   end

`ifdef ODD_DUTY50_EN
   logic neg_q;

   always_ff @(negedge clk_in or negedge rst) begin
      if (!rst) neg_q <= 1'b0;
      else      neg_q <= clk_q;
   end

   // Stretch the high phase by half a cycle for odd ratios only.
   assign clk_out = clk_q | (ratio_q[0] & neg_q);
`else
   assign clk_out = clk_q;
`endif

   assign tick    = tick_q;
   assign cfg_err = err_q;

endmodule

// File: rtl/clk_div_prog.sv
// Multi-channel programmable integer clock divider, all channels on clk_in.
// Optional macro ODD_DUTY50_EN enables 50% duty for odd ratios.
module clk_div_prog
   import clk_div_pkg::*;
#(
   parameter int CH_NUM  = 3,
   parameter int DIV_W   = DIV_W_DEF,
   parameter int DEF_DIV = 2
) (
   input  logic                    clk_in,
   input  logic                    rst,
   input  logic [CH_NUM-1:0]       en,
   input  logic [CH_NUM*DIV_W-1:0] div_in,
   input  logic                    sync,
   output logic [CH_NUM-1:0]       clk_out,
   output logic [CH_NUM-1:0]       tick,
   output logic [CH_NUM-1:0]       cfg_err
);

   for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
      clk_div_ch #(
         .DIV_W   (DIV_W),
         .DEF_DIV (DEF_DIV)
      ) u_ch (
         .clk_in  (clk_in),
         .rst     (rst),
         .en      (en[c]),
         .div_in  (div_in[c*DIV_W +: DIV_W]),
         .sync    (sync),
         .clk_out (clk_out[c]),
         .tick    (tick[c]),
         .cfg_err (cfg_err[c])
      );
   end

endmodule
